tx_skp_inserter: RTL and testbench
==================================

# tx_skp_inserter

Transmit-side SKP ordered-set inserter that sits directly upstream of the 8-bit PCIe scrambler and drives its `data_in`/`k_in` pair. It accepts a byte stream, one symbol per clock, from the link-layer framer over a valid/ready handshake. A periodic interval counter schedules SKP ordered sets (COM + N×SKP), which are inserted only between packets. When there is no upstream data, the block fills the gap with logical idle.

## Interface
- `SKP_INTERVAL`, default 1180: symbol clocks between SKP schedule points; must be ≥ `SKP_COUNT`+2.
- `SKP_COUNT`, default 3: number of SKP symbols that follow each COM; range 1–5.
- `clk`  in  1: symbol clock. The block has one clock.
- `rst`  in  1: reset; synchronous and active-high.
- `in_data`  in  8: upstream symbol.
- `in_k`  in  1: 1 = control symbol, 0 = data.
- `in_valid`  in  1: upstream symbol is valid.
- `in_ready`  out  1: block accepts `in_data` this cycle. This output is combinational.
- `out_data`  out  8: symbol to the scrambler `data_in`. This output is registered.
- `out_k`  out  1: control flag to the scrambler `k_in`. This output is registered.
- `skp_sent`  out  1: 1-cycle pulse, aligned with the COM of an inserted ordered set on `out_*`.
- `err_underrun`  out  1: 1-cycle pulse, aligned with an idle symbol emitted while inside a packet.

## Operation
- Transfer occurs when `in_valid && in_ready`. An accepted symbol appears on `out_data`/`out_k` at the next edge.
- Idle fill: in PASS with no transfer, the output loads `8'h00`, k=0. This is logical idle, which the scrambler scrambles.
- Packet tracking (`in_pkt`, updated only on accepted symbols):
  - Set by K `8'hFB` (STP) or K `8'h5C` (SDP).
  - Cleared by K `8'hFD` (END) or K `8'hFE` (EDB).
  - A repeated STP while already set leaves it set.
- Interval counter:
  - Width is clog2(`SKP_INTERVAL`). Increments every clock, unconditionally.
  - Wraps from `SKP_INTERVAL`-1 to 0.
  - Each wrap increments `pending`, a 2-bit counter that saturates at 3.
- State machine, two states, PASS and SKP:
  - PASS, `pending`≠0, `in_pkt`=0 (insert-decision cycle):
    - `in_ready`=0.
    - Output loads K `8'hBC` (COM) and `skp_sent` is set.
    - `pending` decrements, `skp_idx`←0, next state SKP.
  - PASS otherwise: `in_ready`=1; pass-through or idle fill as above.
  - SKP:
    - `in_ready`=0.
    - Output loads K `8'h1C` and `skp_idx` increments.
    - When `skp_idx`=`SKP_COUNT`-1, next state PASS.
- A complete ordered set occupies `SKP_COUNT`+1 consecutive output cycles, and `in_ready` is low for exactly that many cycles.
- Wrap and decrement in the same cycle leave `pending` unchanged.
- With `pending`≥2 after the first set, the next set begins the cycle immediately after the last SKP, so sets run back-to-back.
- Insertion never splits a packet. It may begin in the cycle after END/EDB is accepted.
- Underrun: state PASS, `in_pkt`=1, `in_valid`=0.
  - Output is idle `8'h00`/k=0.
  - `err_underrun` pulses with that symbol.
  - `in_pkt` is unchanged.
- Upstream is expected to hold `in_valid` high for the whole of a packet. The block does not enforce this.

## Timing
- Reset, while `rst`=1 at an edge:
  - `out_data`=`8'h00`, `out_k`=0, `skp_sent`=0, `err_underrun`=0.
  - State PASS, `pending`=0, counter 0, `in_pkt`=0, `skp_idx`=0.
- `in_ready` is forced to 0 while `rst`=1 and is 1 in the first cycle after release.
- Reset mid-ordered-set aborts the set. The next output is idle `8'h00` and no trailing SKP symbols are emitted.
- Pass-through latency is 1 clock. No combinational path exists from `in_data`/`in_k` to any output.
- Counter first wraps `SKP_INTERVAL` clocks after reset release. In the idle case, COM appears on `out_*` one clock after `pending` becomes nonzero.

## Test plan
All scenarios use `SKP_INTERVAL`=16 and `SKP_COUNT`=3.
- Reset:
  - Drive `rst`=1 for 3 cycles with `in_valid`=1.
  - Required: `out_data`=00 and `out_k`=0 throughout; `in_ready`=0 during reset and 1 in the first cycle after release.
- Idle stream, `in_valid`=0:
  - Required: BC,1C,1C,1C with k=1 once every 16 cycles, then 00.
  - `skp_sent` pulses once per set.
  - `in_ready` is low for 4 cycles per set.
- Pass-through:
  - Stimulus: data bytes 01..0A, k=0, with `in_valid`=1 and no wrap pending.
  - Required: identical bytes on `out_data` exactly 1 cycle later, with no gaps.
- Packet across one wrap:
  - Stimulus: K FB, 20 data bytes, K FD.
  - Required: no BC/1C inside the packet; COM appears 1 cycle after FD is output.
- Packet across two wraps:
  - Stimulus: K FB, 40 data bytes, K FD.
  - Required: after FD, two back-to-back ordered sets (8 symbols); `skp_sent` pulses twice; `in_ready` low for 8 cycles.
- Underrun:
  - Stimulus: after K FB, drop `in_valid` for 2 cycles.
  - Required: two 00/k=0 outputs, each with `err_underrun`=1; a SKP due in that window is still deferred until after FD.
  - Follow-up: assert `rst` on the second SKP cycle of a set; the next output is 00 and no further 1C is emitted.

Source files
------------

// File: rtl/tx_skp_inserter.sv
// Transmit SKP ordered-set inserter feeding the 8-bit scrambler: passes framer symbols through,
// fills gaps with logical idle, and inserts COM + SKP_COUNT x SKP between packets on a fixed interval.
module tx_skp_inserter #(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_k,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_k,
    output logic       skp_sent,
    output logic       err_underrun
);

    localparam int               CNT_W    = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       SKP_LAST = 3'(SKP_COUNT - 1);

    localparam logic [7:0] SYM_IDLE = 8'h00;
    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_SKP  = 8'h1C;
    localparam logic [7:0] SYM_STP  = 8'hFB;
    localparam logic [7:0] SYM_SDP  = 8'h5C;
    localparam logic [7:0] SYM_END  = 8'hFD;
    localparam logic [7:0] SYM_EDB  = 8'hFE;

    typedef enum logic {
        ST_PASS,
        ST_SKP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pending_q, pending_d;
    logic [2:0]       skp_idx_q, skp_idx_d;
    logic             in_pkt_q, in_pkt_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_k_q, out_k_d;
    logic             skp_sent_q, skp_sent_d;
    logic             err_underrun_q, err_underrun_d;

    logic wrap;
    logic insert;
    logic accept;
    logic pkt_start;
    logic pkt_end;

    // A set may only start from PASS while no packet is open; that cycle stalls the framer.
    assign wrap      = (cnt_q == CNT_LAST);
    assign insert    = (state_q == ST_PASS) && (pending_q != 2'd0) && !in_pkt_q;
    assign in_ready  = !rst && (state_q == ST_PASS) && !insert;
    assign accept    = in_valid && in_ready;
    assign pkt_start = in_k && ((in_data == SYM_STP) || (in_data == SYM_SDP));
    assign pkt_end   = in_k && ((in_data == SYM_END) || (in_data == SYM_EDB));

    assign cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);

    // A wrap coinciding with a set start cancels out; the backlog saturates at 3.
    always_comb begin
        pending_d = pending_q;
        if (wrap && !insert) begin
            if (pending_q != 2'd3) begin
                pending_d = pending_q + 2'd1;
            end
        end else if (insert && !wrap) begin
            pending_d = pending_q - 2'd1;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        state_d        = state_q;
        skp_idx_d      = skp_idx_q;
        in_pkt_d       = in_pkt_q;
        out_data_d     = SYM_IDLE;
        out_k_d        = 1'b0;
        skp_sent_d     = 1'b0;
        err_underrun_d = 1'b0;

        case (state_q)
            ST_PASS: begin
                if (insert) begin
                    out_data_d = SYM_COM;
                    out_k_d    = 1'b1;
                    skp_sent_d = 1'b1;
                    skp_idx_d  = 3'd0;
                    state_d    = ST_SKP;
                end else if (accept) begin
                    out_data_d = in_data;
                    out_k_d    = in_k;
                    if (pkt_start) begin
                        in_pkt_d = 1'b1;
                    end else if (pkt_end) begin
                        in_pkt_d = 1'b0;
                    end
                end else if (in_pkt_q) begin
                    err_underrun_d = 1'b1;
                end
            end
            ST_SKP: begin
                out_data_d = SYM_SKP;
                out_k_d    = 1'b1;
                skp_idx_d  = skp_idx_q + 3'd1;
                if (skp_idx_q == SKP_LAST) begin
                    state_d = ST_PASS;
                end
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_PASS;
            cnt_q          <= '0;
            pending_q      <= 2'd0;
            skp_idx_q      <= 3'd0;
            in_pkt_q       <= 1'b0;
            out_data_q     <= SYM_IDLE;
            out_k_q        <= 1'b0;
            skp_sent_q     <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            skp_idx_q      <= skp_idx_d;
            in_pkt_q       <= in_pkt_d;
            out_data_q     <= out_data_d;
            out_k_q        <= out_k_d;
            skp_sent_q     <= skp_sent_d;
            err_underrun_q <= err_underrun_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_k        = out_k_q;
    assign skp_sent     = skp_sent_q;
    assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_tx_skp_inserter.sv
// Directed bench for tx_skp_inserter with SKP_INTERVAL=16, SKP_COUNT=3.
// Cycle c is the interval between edge c and edge c+1, counted from the last reset edge.
module tb_tx_skp_inserter;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_k;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_k;
    logic       skp_sent;
    logic       err_underrun;

    int n_checks;
    int n_errors;
    int cyc;

    tx_skp_inserter #(
        .SKP_INTERVAL(16),
        .SKP_COUNT   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_k        (in_k),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_k       (out_k),
        .skp_sent    (skp_sent),
        .err_underrun(err_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s @cycle %0d: observed %02h expected %02h", tag, cyc, observed, expected);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic k,
                           input logic s, input logic e);
        check({tag, " out_data"}, out_data, d);
        check({tag, " out_k"}, {7'd0, out_k}, {7'd0, k});
        check({tag, " skp_sent"}, {7'd0, skp_sent}, {7'd0, s});
        check({tag, " err_underrun"}, {7'd0, err_underrun}, {7'd0, e});
    endtask

    // Drive cycle cyc, check in_ready, then check what the next edge loaded.
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic k,
                        input logic rdy, input logic [7:0] od, input logic ok,
                        input logic os, input logic oe);
        in_valid = v;
        in_data  = d;
        in_k     = k;
        #1;
        check({tag, " in_ready"}, {7'd0, in_ready}, {7'd0, rdy});
        @(posedge clk);
        #1;
        cyc++;
        chk_out(tag, od, ok, os, oe);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_k     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic [7:0] od;
        logic       ok;
        logic       os;
        logic       rdy;
        logic       is_skp;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;

        // Reset held for three edges with a valid symbol offered.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_k     = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
            check("reset in_ready", {7'd0, in_ready}, 8'h00);
        end
        rst = 1'b0;
        cyc = 0;

        // First cycle after release accepts at once.
        step("release", 1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);

        // Pass-through 01..0A, one cycle latency, no gaps.
        for (int i = 1; i <= 10; i++) begin
            step("pass", 1'b1, 8'(i), 1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        end

        // Idle: wraps at edges 16 and 32, so sets occupy edges 17..20 and 33..36.
        for (int c = 11; c <= 36; c++) begin
            os     = ((c + 1) == 17) || ((c + 1) == 33);
            is_skp = ((c + 1) >= 18 && (c + 1) <= 20) || ((c + 1) >= 34 && (c + 1) <= 36);
            od     = os ? 8'hBC : (is_skp ? 8'h1C : 8'h00);
            ok     = os || is_skp;
            rdy    = !((c >= 16 && c <= 19) || (c >= 32 && c <= 35));
            step("idle", 1'b0, 8'h00, 1'b0, rdy, od, ok, os, 1'b0);
        end

        // Packet spanning one wrap (edge 16): set deferred until FD has gone out.
        do_reset();
        step("pkt1 stp", 1'b1, 8'hFB, 1'b1, 1'b1, 8'hFB, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step("pkt1 data", 1'b1, 8'(8'h20 + i), 1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        end
        step("pkt1 end", 1'b1, 8'hFD, 1'b1, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0);
        step("pkt1 com", 1'b0, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("pkt1 skp", 1'b0, 8'h00, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b0);
        end
        step("pkt1 after", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

        // Packet spanning two wraps (edges 16, 32): two sets back-to-back on edges 43..50.
        // The interval fires again on edge 48, so a third set follows on edges 51..54.
        do_reset();
        step("pkt2 stp", 1'b1, 8'hFB, 1'b1, 1'b1, 8'hFB, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            step("pkt2 data", 1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        end
        step("pkt2 end", 1'b1, 8'hFD, 1'b1, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0);
        for (int c = 42; c <= 54; c++) begin
            os     = ((c + 1) == 43) || ((c + 1) == 47) || ((c + 1) == 51);
            is_skp = ((c + 1) >= 44 && (c + 1) <= 54) && !os;
            od     = os ? 8'hBC : (is_skp ? 8'h1C : 8'h00);
            ok     = os || is_skp;
            rdy    = (c == 54);
            step("pkt2 sets", 1'b0, 8'h00, 1'b0, rdy, od, ok, os, 1'b0);
        end

        // Underrun straddling the wrap at edge 16: idle with err pulse, set held until after FD.
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            step("pre", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        step("urun stp", 1'b1, 8'hFB, 1'b1, 1'b1, 8'hFB, 1'b1, 1'b0, 1'b0);
        step("urun gap1", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        step("urun gap2", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        step("urun data", 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step("urun end", 1'b1, 8'hFD, 1'b1, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0);
        step("urun com", 1'b0, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("urun skp", 1'b0, 8'h00, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b0);
        end
        for (int c = 23; c <= 31; c++) begin
            step("urun idle", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // Reset during the second SKP cycle of the set started by the wrap at edge 32.
        step("abort com", 1'b0, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b1, 1'b0);
        step("abort skp", 1'b0, 8'h00, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("abort in_ready", {7'd0, in_ready}, 8'h00);
        @(posedge clk);
        #1;
        cyc++;
        chk_out("abort rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 5; c++) begin
            step("abort after", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
